// File: rtl/sort_pkg.sv
// rtl/sort_pkg.sv - shared ALU opcodes, sort FSM states and compare-pair table
package sort_pkg;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;

  typedef enum logic {ST_IDLE, ST_CMP} state_t;

  localparam logic [2:0] LAST_STEP = 3'd5;

  // Lower index of the adjacent pair compared at each step of the 4-entry network
  function automatic logic [1:0] pair_lo(input logic [2:0] step);
    case (step)
      3'd0:    pair_lo = 2'd0;
      3'd1:    pair_lo = 2'd1;
      3'd2:    pair_lo = 2'd2;
      3'd3:    pair_lo = 2'd0;
      3'd4:    pair_lo = 2'd1;
      default: pair_lo = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/alu.sv
// rtl/alu.sv - combinational ALU with zero, carry/borrow and overflow flags
module alu
  import sort_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       m,
  output logic [WIDTH-1:0] y,
  output logic             zf,
  output logic             cf,
  output logic             of
);

  logic [WIDTH:0] ext;

  // For SUB, cf is the borrow: set when a < b unsigned
  always_comb begin
    ext = '0;
    of  = 1'b0;
    case (m)
      ALU_ADD: begin
        ext = {1'b0, a} + {1'b0, b};
        of  = (a[WIDTH-1] == b[WIDTH-1]) && (ext[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_SUB: begin
        ext = {1'b0, a} - {1'b0, b};
        of  = (a[WIDTH-1] != b[WIDTH-1]) && (ext[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_AND: ext = {1'b0, a & b};
      ALU_OR:  ext = {1'b0, a | b};
      ALU_XOR: ext = {1'b0, a ^ b};
      default: ext = '0;
    endcase
  end

  assign y  = ext[WIDTH-1:0];
  assign cf = ext[WIDTH];
  assign zf = (ext[WIDTH-1:0] == '0);

endmodule

// File: rtl/sort_top.sv
// rtl/sort_top.sv - sorting controller paired with its ALU
module sort_top
  import sort_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int SIGNED = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] x0,
  input  logic [WIDTH-1:0] x1,
  input  logic [WIDTH-1:0] x2,
  input  logic [WIDTH-1:0] x3,
  output logic [WIDTH-1:0] s0,
  output logic [WIDTH-1:0] s1,
  output logic [WIDTH-1:0] s2,
  output logic [WIDTH-1:0] s3,
  output logic             busy,
  output logic             done,
  output logic [2:0]       swap_cnt
);

  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [WIDTH-1:0] alu_y;
  logic [2:0]       alu_m;
  logic             alu_zf;
  logic             alu_cf;
  logic             alu_of;

  alu #(.WIDTH(WIDTH)) u_alu (
    .a(alu_a), .b(alu_b), .m(alu_m), .y(alu_y), .zf(alu_zf), .cf(alu_cf), .of(alu_of)
  );

  alu_sort_ctrl #(.WIDTH(WIDTH), .SIGNED(SIGNED)) u_ctrl (
    .clk(clk), .rst_n(rst_n), .start(start),
    .x0(x0), .x1(x1), .x2(x2), .x3(x3),
    .s0(s0), .s1(s1), .s2(s2), .s3(s3),
    .busy(busy), .done(done), .swap_cnt(swap_cnt),
    .alu_a(alu_a), .alu_b(alu_b), .alu_m(alu_m), .alu_y(alu_y),
    .alu_zf(alu_zf), .alu_cf(alu_cf), .alu_of(alu_of)
  );

endmodule

// File: rtl/alu_sort_ctrl.sv
// rtl/alu_sort_ctrl.sv - 4-entry compare-and-swap sorter driving an external ALU
module alu_sort_ctrl
  import sort_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int SIGNED = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] x0,
  input  logic [WIDTH-1:0] x1,
  input  logic [WIDTH-1:0] x2,
  input  logic [WIDTH-1:0] x3,
  output logic [WIDTH-1:0] s0,
  output logic [WIDTH-1:0] s1,
  output logic [WIDTH-1:0] s2,
  output logic [WIDTH-1:0] s3,
  output logic             busy,
  output logic             done,
  output logic [2:0]       swap_cnt,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_m,
  input  logic [WIDTH-1:0] alu_y,
  input  logic             alu_zf,
  input  logic             alu_cf,
  input  logic             alu_of
);

  // Flipping the MSB maps two's-complement order onto unsigned order
  localparam logic [WIDTH-1:0] BIAS = (SIGNED != 0) ? {1'b1, {(WIDTH-1){1'b0}}} : '0;

  state_t           state;
  logic [2:0]       step;
  logic [2:0]       cnt;
  logic [WIDTH-1:0] r  [4];
  logic [WIDTH-1:0] nr [4];
  logic [1:0]       lo;
  logic [1:0]       hi;
  logic             swap;
  logic [2:0]       cnt_next;
  logic             unused_dbg;

  assign unused_dbg = ^{alu_y, alu_of};

  always_comb begin
    lo    = pair_lo(step);
    hi    = lo + 2'd1;
    alu_a = '0;
    alu_b = '0;
    alu_m = ALU_ADD;
    if (state == ST_CMP) begin
      alu_a = r[lo] ^ BIAS;
      alu_b = r[hi] ^ BIAS;
      alu_m = ALU_SUB;
    end
  end

  // No borrow and non-zero difference means a > b; equal pairs stay put
  assign swap     = (state == ST_CMP) && !alu_cf && !alu_zf;
  assign cnt_next = cnt + {2'b00, swap};

  always_comb begin
    for (int i = 0; i < 4; i++) nr[i] = r[i];
    if (swap) begin
      nr[lo] = r[hi];
      nr[hi] = r[lo];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      step     <= '0;
      cnt      <= '0;
      for (int i = 0; i < 4; i++) r[i] <= '0;
      s0       <= '0;
      s1       <= '0;
      s2       <= '0;
      s3       <= '0;
      swap_cnt <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            r[0]  <= x0;
            r[1]  <= x1;
            r[2]  <= x2;
            r[3]  <= x3;
            step  <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= ST_CMP;
          end
        end
        ST_CMP: begin
          for (int i = 0; i < 4; i++) r[i] <= nr[i];
          cnt  <= cnt_next;
          step <= step + 3'd1;
          if (step == LAST_STEP) begin
            s0       <= nr[0];
            s1       <= nr[1];
            s2       <= nr[2];
            s3       <= nr[3];
            swap_cnt <= cnt_next;
            done     <= 1'b1;
            busy     <= 1'b0;
            state    <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
